// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared constants, types and helpers for the serial_tx transmit path
//
// Contents:
//   - line rate constants (40 MHz clock, 10 Mbps line)
//   - K28.5 comma constants (data byte and both running-disparity code words)
//   - payload byte field positions
//   - running disparity type, odd-parity helper and payload byte builder
package serial_tx_pkg;

    localparam int CLK_HZ      = 40_000_000;
    localparam int LINE_BPS    = 10_000_000;
    localparam int CLK_PER_BIT = CLK_HZ / LINE_BPS;
    localparam int FRAME_SYMS  = 256;
    localparam int SYM_BITS    = 10;

    localparam logic [7:0] K28_5_DATA = 8'hBC;
    localparam logic [9:0] K28_5_RDN  = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP  = 10'b1100000101;

    // Payload byte layout: [7] IsPro, [6] IsMaster, [5] RawPls, [4] P1, [3:1] Option, [0] P2
    localparam int BIT_IS_PRO    = 7;
    localparam int BIT_IS_MASTER = 6;
    localparam int BIT_RAW_PLS   = 5;
    localparam int BIT_P1        = 4;
    localparam int BIT_OPT_HI    = 3;
    localparam int BIT_OPT_LO    = 1;
    localparam int BIT_P2        = 0;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_t;

    // Parity bit that makes the XOR of the three covered bits plus itself equal 1.
    function automatic logic odd_parity(input logic [2:0] bits);
        return ~^bits;
    endfunction

    function automatic logic [7:0] build_byte(
        input logic       is_pro,
        input logic       is_master,
        input logic       raw_pls,
        input logic [2:0] option
    );
        logic [7:0] b;
        b                         = '0;
        b[BIT_IS_PRO]             = is_pro;
        b[BIT_IS_MASTER]          = is_master;
        b[BIT_RAW_PLS]            = raw_pls;
        b[BIT_P1]                 = odd_parity({is_pro, is_master, raw_pls});
        b[BIT_OPT_HI:BIT_OPT_LO]  = option;
        b[BIT_P2]                 = odd_parity(option);
        return b;
    endfunction

endpackage

// File: rtl/encode_8b10b.sv
// rtl/encode_8b10b.sv - combinational 8b10b encoder, inverse of decode_8b10b
//
// Ports:
//   datain[7:0]  byte to encode (HGF EDCBA)
//   kin          1 = control symbol; only K28.5 is ever requested, so any kin
//                request produces the K28.5 code word
//   dispin       running disparity in (0 = RD-, 1 = RD+)
//   dataout[9:0] code word, dataout[9] = a (sent first) ... dataout[0] = j
//   dispout      running disparity after this code word
module encode_8b10b
    import serial_tx_pkg::*;
(
    input  logic [7:0] datain,
    input  logic       kin,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6;
    logic       unbal4;
    logic       rd6;
    logic       alt7;

    always_comb begin
        x       = datain[4:0];
        y       = datain[7:5];
        c6      = 6'b000000;
        c4      = 4'b0000;
        unbal6  = 1'b0;
        unbal4  = 1'b0;
        rd6     = dispin;
        alt7    = 1'b0;
        dataout = 10'b0000000000;
        dispout = dispin;

        // 5b/6b: RD- column; the RD+ form is the complement for unbalanced
        // codes and for D.07, whose balanced code still alternates.
        case (x)
            5'd0:    c6 = 6'b100111;
            5'd1:    c6 = 6'b011101;
            5'd2:    c6 = 6'b101101;
            5'd3:    c6 = 6'b110001;
            5'd4:    c6 = 6'b110101;
            5'd5:    c6 = 6'b101001;
            5'd6:    c6 = 6'b011001;
            5'd7:    c6 = 6'b111000;
            5'd8:    c6 = 6'b111001;
            5'd9:    c6 = 6'b100101;
            5'd10:   c6 = 6'b010101;
            5'd11:   c6 = 6'b110100;
            5'd12:   c6 = 6'b001101;
            5'd13:   c6 = 6'b101100;
            5'd14:   c6 = 6'b011100;
            5'd15:   c6 = 6'b010111;
            5'd16:   c6 = 6'b011011;
            5'd17:   c6 = 6'b100011;
            5'd18:   c6 = 6'b010011;
            5'd19:   c6 = 6'b110010;
            5'd20:   c6 = 6'b001011;
            5'd21:   c6 = 6'b101010;
            5'd22:   c6 = 6'b011010;
            5'd23:   c6 = 6'b111010;
            5'd24:   c6 = 6'b110011;
            5'd25:   c6 = 6'b100110;
            5'd26:   c6 = 6'b010110;
            5'd27:   c6 = 6'b110110;
            5'd28:   c6 = 6'b001110;
            5'd29:   c6 = 6'b101110;
            5'd30:   c6 = 6'b011110;
            default: c6 = 6'b101011;
        endcase
        unbal6 = ($countones(c6) != 3);
        if (dispin && (unbal6 || (x == 5'd7))) begin
            c6 = ~c6;
        end
        rd6 = dispin ^ unbal6;

        // D.x.A7 replaces D.x.P7 where P7 would create a run of five equal bits.
        alt7 = (y == 3'd7) &&
               ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

        // 3b/4b: RD- column, same complement rule (D.x.3 alternates while balanced).
        case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
        unbal4 = ($countones(c4) != 2);
        if (rd6 && (unbal4 || (y == 3'd3))) begin
            c4 = ~c4;
        end

        dataout = {c6, c4};
        dispout = rd6 ^ unbal4;

        if (kin) begin
            dataout = dispin ? K28_5_RDP : K28_5_RDN;
            dispout = ~dispin;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - flag packer, 8b10b encoder and MSB-first serializer for the SFP link
//
// Optional feature macro: SERIAL_TX_INPUT_SYNC_EN (2-FF synchronizers on payload
// inputs and i_tx_en, adds 2 clocks of latency).
//
// Ports:
//   i_clk         40 MHz clock
//   i_res_n       asynchronous active-low reset
//   i_tx_en       transmit enable; low clears the sequencer on the next clock
//   i_IsPro       payload flag, byte bit 7
//   i_IsMaster    payload flag, byte bit 6
//   i_RawPls      raw pulse flag, byte bit 5
//   i_Option[2:0] option field, byte bits 3:1
//   o_SerialData  registered line bit to the SFP TXD
//   o_tx_dis      SFP TX_DISABLE, active-high
//   o_tx_led[1:0] [0] red = not transmitting, [1] green = RawPls of last data symbol
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int P_CLK_PER_BIT = CLK_PER_BIT,
    parameter int P_FRAME_SYMS  = FRAME_SYMS
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_tx_en,
    input  logic       i_IsPro,
    input  logic       i_IsMaster,
    input  logic       i_RawPls,
    input  logic [2:0] i_Option,
    output logic       o_SerialData,
    output logic       o_tx_dis,
    output logic [1:0] o_tx_led
);

    localparam int PW = (P_CLK_PER_BIT > 1) ? $clog2(P_CLK_PER_BIT) : 1;
    localparam int SW = (P_FRAME_SYMS > 1) ? $clog2(P_FRAME_SYMS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(P_CLK_PER_BIT - 1);
    localparam logic [SW-1:0] SYM_MAX   = SW'(P_FRAME_SYMS - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(SYM_BITS - 1);

    logic       tx_en;
    logic       is_pro;
    logic       is_master;
    logic       raw_pls;
    logic [2:0] option;

`ifdef SERIAL_TX_INPUT_SYNC_EN
    logic [6:0] sync_q1;
    logic [6:0] sync_q2;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {i_tx_en, i_IsPro, i_IsMaster, i_RawPls, i_Option};
            sync_q2 <= sync_q1;
        end
    end

    assign {tx_en, is_pro, is_master, raw_pls, option} = sync_q2;
`else
    assign {tx_en, is_pro, is_master, raw_pls, option} =
        {i_tx_en, i_IsPro, i_IsMaster, i_RawPls, i_Option};
`endif

    logic [PW-1:0]       presc;
    logic [3:0]          bit_idx;
    logic [SW-1:0]       sym_cnt;
    logic [SYM_BITS-1:0] shift_reg;
    rd_t                 rd;
    logic                serial_data;
    logic                tx_dis;
    logic                led_green;

    logic       presc_last;
    logic       load;
    logic       sym_is_k;
    logic [7:0] data_byte;
    logic [7:0] enc_in;
    logic [9:0] enc_out;
    logic       enc_disp;

    assign presc_last = (presc == PRESC_MAX);
    assign load       = presc_last && (bit_idx == BIT_LAST);
    // Symbol 0 of every frame is the comma, so a load on the wrap selects K28.5.
    assign sym_is_k   = (sym_cnt == '0);
    assign data_byte  = build_byte(is_pro, is_master, raw_pls, option);
    assign enc_in     = sym_is_k ? K28_5_DATA : data_byte;

    encode_8b10b u_encode (
        .datain  (enc_in),
        .kin     (sym_is_k),
        .dispin  (rd == RD_POS),
        .dataout (enc_out),
        .dispout (enc_disp)
    );

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            presc       <= '0;
            bit_idx     <= '0;
            sym_cnt     <= '0;
            shift_reg   <= '0;
            rd          <= RD_NEG;
            serial_data <= 1'b0;
            tx_dis      <= 1'b1;
            led_green   <= 1'b0;
        end else if (!tx_en) begin
            // Disable wins over a coincident load; re-enable restarts from K28.5 at RD-.
            presc       <= '0;
            bit_idx     <= '0;
            sym_cnt     <= '0;
            shift_reg   <= '0;
            rd          <= RD_NEG;
            serial_data <= 1'b0;
            tx_dis      <= 1'b1;
        end else begin
            tx_dis      <= 1'b0;
            serial_data <= shift_reg[SYM_BITS-1];
            presc       <= presc_last ? '0 : presc + PW'(1);
            if (load) begin
                bit_idx   <= '0;
                shift_reg <= enc_out;
                rd        <= enc_disp ? RD_POS : RD_NEG;
                sym_cnt   <= (sym_cnt == SYM_MAX) ? '0 : sym_cnt + SW'(1);
                if (!sym_is_k) begin
                    led_green <= raw_pls;
                end
            end else if (presc_last) begin
                bit_idx   <= bit_idx + 4'd1;
                shift_reg <= {shift_reg[SYM_BITS-2:0], 1'b0};
            end
        end
    end

    assign o_SerialData = serial_data;
    assign o_tx_dis     = tx_dis;
    assign o_tx_led     = {led_green, tx_dis};

endmodule
